// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter that serialises one granted byte per frame onto a shared line.
// Frame format: start 0, 8 data bits LSB first, stop 1, then GAP_BITS idle cycles.
module serial_tx_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int GAP_BITS = 1,
  parameter int IDW      = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 tx,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 frame_done
);

  localparam int             GCW       = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [GCW-1:0] GAP_LAST  = GCW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic [IDW-1:0] LAST_INIT = IDW'(NUM_REQ - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

  state_t         state, state_n;
  logic [7:0]     shift, shift_n;
  logic [2:0]     bit_cnt, bit_cnt_n;
  logic [GCW-1:0] gap_cnt, gap_cnt_n;
  logic [IDW-1:0] last, last_n;
  logic [IDW-1:0] grant_id_n;
  logic [IDW-1:0] win, cand;
  logic           win_valid;
  logic           tx_n, busy_n, frame_done_n;
  logic [7:0]     req_bytes [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_bytes[i] = req_data[8*i +: 8];
    end
  end

  // Scan starting just after the last winner so every requester gets a turn.
  always_comb begin
    win       = '0;
    cand      = '0;
    win_valid = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((int'(last) + k) % NUM_REQ);
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win       = cand;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (state == IDLE && en && win_valid && !reset) begin
      gnt[win] = 1'b1;
    end
  end

  // Output values are computed for the state being entered so tx/busy/frame_done come straight from flops.
  always_comb begin
    state_n      = state;
    shift_n      = shift;
    bit_cnt_n    = bit_cnt;
    gap_cnt_n    = gap_cnt;
    last_n       = last;
    grant_id_n   = grant_id;
    tx_n         = 1'b1;
    busy_n       = 1'b0;
    frame_done_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (en && win_valid) begin
          state_n    = START;
          shift_n    = req_bytes[win];
          grant_id_n = win;
          last_n     = win;
          tx_n       = 1'b0;
          busy_n     = 1'b1;
        end
      end
      START: begin
        state_n   = DATA;
        bit_cnt_n = '0;
        tx_n      = shift[0];
        shift_n   = {1'b0, shift[7:1]};
        busy_n    = 1'b1;
      end
      DATA: begin
        busy_n = 1'b1;
        if (bit_cnt == 3'd7) begin
          state_n      = STOP;
          frame_done_n = 1'b1;
        end else begin
          bit_cnt_n = bit_cnt + 3'd1;
          tx_n      = shift[0];
          shift_n   = {1'b0, shift[7:1]};
        end
      end
      STOP: begin
        if (GAP_BITS > 0) begin
          state_n   = GAP;
          gap_cnt_n = '0;
          busy_n    = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_n = IDLE;
        end else begin
          gap_cnt_n = gap_cnt + 1'b1;
          busy_n    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      last       <= LAST_INIT;
      grant_id   <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      shift      <= shift_n;
      bit_cnt    <= bit_cnt_n;
      gap_cnt    <= gap_cnt_n;
      last       <= last_n;
      grant_id   <= grant_id_n;
      tx         <= tx_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
    end
  end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter: a line monitor deserialises frames and checks
// them against a scoreboard of expected {requester, byte} pushed at each grant.
module tb_serial_tx_arbiter;
  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [7:0]     data;
  } exp_t;

  logic           clk, reset, en;
  logic [3:0]     req, gnt, req_g, gnt_g;
  logic [31:0]    req_data, req_data_g, dvec;
  logic           tx, busy, frame_done;
  logic           tx_g, busy_g, frame_done_g;
  logic [IDW-1:0] grant_id, grant_id_g;

  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   frames_seen = 0;
  int   n, frames_before;
  logic prev_g;
  exp_t sb[$];
  int   start_times[$];
  int   g_starts[$];

  serial_tx_arbiter #(.NUM_REQ(NUM_REQ), .GAP_BITS(1), .IDW(IDW)) u_dut (
    .clk(clk), .reset(reset), .en(en), .req(req), .req_data(req_data),
    .gnt(gnt), .tx(tx), .busy(busy), .grant_id(grant_id), .frame_done(frame_done)
  );

  serial_tx_arbiter #(.NUM_REQ(NUM_REQ), .GAP_BITS(0), .IDW(IDW)) u_dut_g0 (
    .clk(clk), .reset(reset), .en(en), .req(req_g), .req_data(req_data_g),
    .gnt(gnt_g), .tx(tx_g), .busy(busy_g), .grant_id(grant_id_g), .frame_done(frame_done_g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d, input logic e);
    req      = r;
    req_data = d;
    en       = e;
  endtask

  function automatic logic [7:0] byteVal(input int k);
    return 8'((k * 37 + 11) & 255);
  endfunction

  // Waits for a grant, checks it, records the expected frame; returns 1 ns after the grant edge.
  task automatic waitGrant(input int idx, input int budget);
    int waited;
    waited = 0;
    @(negedge clk);
    while (gnt == 4'b0000 && waited < budget) begin
      waited++;
      @(negedge clk);
    end
    checkOutput("gnt_onehot", {28'b0, gnt}, 32'(1) << idx);
    checkOutput("busy_at_gnt", {31'b0, busy}, 32'd0);
    if (gnt == 4'(1 << idx)) begin
      sb.push_back('{id: IDW'(idx), data: req_data[8*idx +: 8]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle(input int budget, output int cnt);
    cnt = 0;
    @(negedge clk);
    while (busy && cnt < budget) begin
      cnt++;
      @(negedge clk);
    end
    if (busy) checkOutput("idle_timeout", {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Line monitor: deserialises each frame on tx and compares it with the scoreboard head.
  initial begin
    int         bit_pos;
    logic [7:0] mon_byte;
    exp_t       e;
    bit_pos  = -1;
    mon_byte = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        bit_pos = -1;
      end else if (bit_pos < 0) begin
        if (tx == 1'b0) begin
          bit_pos = 1;
          start_times.push_back(cyc);
          checkOutput("busy_in_frame", {31'b0, busy}, 32'd1);
        end
      end else if (bit_pos <= 8) begin
        mon_byte = {tx, mon_byte[7:1]};
        bit_pos++;
      end else begin
        checkOutput("stop_bit", {31'b0, tx}, 32'd1);
        checkOutput("frame_done", {31'b0, frame_done}, 32'd1);
        checkOutput("sb_has_entry", {31'b0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checkOutput("frame_data", {24'b0, mon_byte}, {24'b0, e.data});
          checkOutput("frame_id", {30'b0, grant_id}, {30'b0, e.id});
        end
        frames_seen++;
        bit_pos = -1;
      end
      if (busy && !reset) checkOutput("no_gnt_busy", {28'b0, gnt}, 32'd0);
    end
  end

  initial begin
    $display("[TB] serial_tx_arbiter bench start");
    req_g      = '0;
    req_data_g = '0;
    reset      = 1'b1;
    applyStimulus(4'b0000, 32'h0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_tx", {31'b0, tx}, 32'd1);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_gnt", {28'b0, gnt}, 32'd0);
    checkOutput("rst_frame_done", {31'b0, frame_done}, 32'd0);
    checkOutput("rst_grant_id", {30'b0, grant_id}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] single byte 0xA5 from requester 0");
    applyStimulus(4'b0001, 32'h0000_00A5, 1'b1);
    waitGrant(0, 3);
    applyStimulus(4'b0000, 32'h0000_00A5, 1'b1);
    waitIdle(50, n);
    checkOutput("busy_len", 32'(n), 32'd11);

    $display("[TB] simultaneous requests 1 and 2");
    start_times.delete();
    applyStimulus(4'b0110, 32'h00C3_3C00, 1'b1);
    waitGrant(1, 3);
    applyStimulus(4'b0100, 32'h00C3_3C00, 1'b1);
    waitGrant(2, 20);
    applyStimulus(4'b0000, 32'h0, 1'b1);
    waitIdle(50, n);
    checkOutput("two_starts", 32'(start_times.size()), 32'd2);
    if (start_times.size() >= 2) checkOutput("start_spacing", 32'(start_times[1] - start_times[0]), 32'd12);

    $display("[TB] round-robin fairness, all requesting");
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) dvec[8*k +: 8] = byteVal(k);
    applyStimulus(4'b1111, dvec, 1'b1);
    for (int k = 0; k < 8; k++) begin
      waitGrant(k % 4, 20);
      dvec[8*(k % 4) +: 8] = byteVal(k + 4);
      applyStimulus(4'b1111, dvec, 1'b1);
    end
    applyStimulus(4'b0000, dvec, 1'b1);
    waitIdle(50, n);

    $display("[TB] reset during 4th data bit");
    applyStimulus(4'b0001, 32'h0000_000F, 1'b1);
    waitGrant(0, 3);
    applyStimulus(4'b0000, 32'h0000_000F, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_tx", {31'b0, tx}, 32'd1);
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    checkOutput("abort_frame_done", {31'b0, frame_done}, 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(4'b1000, 32'h9600_0000, 1'b1);
    waitGrant(3, 3);
    applyStimulus(4'b0000, 32'h0, 1'b1);
    waitIdle(50, n);

    $display("[TB] enable held low, then raised, then dropped mid-frame");
    applyStimulus(4'b0001, 32'h0000_003C, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("en_low_gnt", {28'b0, gnt}, 32'd0);
      checkOutput("en_low_tx", {31'b0, tx}, 32'd1);
    end
    @(posedge clk);
    #1;
    frames_before = frames_seen;
    applyStimulus(4'b0001, 32'h0000_003C, 1'b1);
    waitGrant(0, 0);
    applyStimulus(4'b0000, 32'h0000_003C, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(4'b0000, 32'h0, 1'b0);
    waitIdle(50, n);
    checkOutput("en_drop_frame", 32'(frames_seen - frames_before), 32'd1);

    $display("[TB] GAP_BITS=0 back-to-back frames");
    req_data_g = 32'hFFFF_FFFF;
    req_g      = 4'b0011;
    en         = 1'b1;
    prev_g     = 1'b1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (prev_g && !tx_g) g_starts.push_back(cyc);
      prev_g = tx_g;
    end
    req_g = 4'b0000;
    checkOutput("g0_starts", {31'b0, g_starts.size() >= 3}, 32'd1);
    if (g_starts.size() >= 3) begin
      checkOutput("g0_spacing_a", 32'(g_starts[1] - g_starts[0]), 32'd11);
      checkOutput("g0_spacing_b", 32'(g_starts[2] - g_starts[1]), 32'd11);
    end
    n = 0;
    while (busy_g && n < 30) begin
      n++;
      @(negedge clk);
    end
    checkOutput("g0_idle", {31'b0, busy_g}, 32'd0);

    repeat (3) @(posedge clk);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    checkOutput("frames_total", 32'(frames_seen), 32'd13);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_tx_arbiter.md
Name: serial_tx_arbiter

Overview:
Shares one serial transmit line among NUM_REQ byte requesters using round-robin arbitration. Each granted byte goes out as one frame in the line format used by the team's serial byte receivers: start bit 0, 8 data bits LSB first, stop bit 1, idle level 1. Bit rate is one bit per clk cycle. Sits between local byte producers and the shared serial link.

Parameters:
NUM_REQ, 4, number of requesters (>=2).
GAP_BITS, 1, extra idle-1 cycles forced after each stop bit (>=0).
IDW, $clog2(NUM_REQ), width of grant_id.

Ports:
clk  input  1  clock; all state changes on rising edge.
reset  input  1  synchronous, active-high.
en  input  1  grant enable; low blocks new grants, never aborts a frame in flight.
req  input  NUM_REQ  per-requester byte-valid; held high until gnt.
req_data  input  8*NUM_REQ  byte for requester i in bits [8i+7:8i]; stable while req[i] high.
gnt  output  NUM_REQ  one-hot; high for one cycle when the byte of requester i is accepted.
tx  output  1  registered serial line; idles at 1.
busy  output  1  high while a frame is in progress (any state except IDLE).
grant_id  output  IDW  index of the requester being sent; valid while busy.
frame_done  output  1  one-cycle pulse during the stop-bit cycle.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values: tx=1, busy=0, gnt=0, frame_done=0, grant_id=0, state=IDLE, round-robin pointer last=NUM_REQ-1, so requester 0 has top priority first.
- States: IDLE, START, DATA, STOP, GAP. DATA uses a 3-bit bit counter.
- IDLE: tx=1. If en && |req, then in that same cycle (combinationally from state, req, and last), gnt[w]=1, where w is the first set req index scanning last+1, last+2, ... modulo NUM_REQ. On that edge: shift register <= req_data[w], grant_id<=w, last<=w, state<=START. Otherwise stay in IDLE.
- gnt is high only in IDLE with en=1, at most one bit set. Requester drops req or presents its next byte on the cycle after gnt.
- START: tx=0 for 1 cycle, then DATA.
- DATA: tx=shift[0], then shift right. Lasts 8 cycles, bit 0 first. After the 8th bit go to STOP.
- STOP: tx=1, frame_done=1, for 1 cycle. Next state is GAP if GAP_BITS>0, else IDLE.
- GAP: tx=1 for GAP_BITS cycles, then IDLE.
- Frame timing: if the grant cycle is t, start is at t+1, data at t+2..t+9, stop at t+10. The earliest next grant is at t+11+GAP_BITS. Minimum idle time between frames is GAP_BITS+1 cycles of tx=1.
- busy=1 from START through the last GAP cycle. busy=0 in IDLE, including the grant cycle.
- tx, busy, grant_id, and frame_done are registered and glitch-free. gnt is the only combinational output.
- req changes during a frame are ignored. Arbitration happens only in IDLE, so a request arriving mid-frame waits.
- en deasserted mid-frame: the frame completes normally. Only the next grant is blocked.
- Fairness: with all req high continuously, the grant order is 0,1,...,NUM_REQ-1,0,...
- A single active requester is granted every frame slot.
- Reset mid-frame: the next cycle has tx=1, state=IDLE, and pointer last=NUM_REQ-1. The partial frame is abandoned, with no frame_done and no gnt that cycle. A receiver on the line will see a framing error and recover on idle-1.
- req bits at indices >=NUM_REQ do not exist; no out-of-range grant_id is ever produced.

Test Plan:
- Single byte, GAP_BITS=1: req[0]=1, data 0xA5 in idle → gnt[0] pulses 1 cycle. tx over the next 10 cycles = 0,1,0,1,0,0,1,0,1,1. frame_done is high on the 10th. busy is high for 11 cycles (10 frame cycles plus 1 gap), grant_id=0.
- Simultaneous requests: req=4'b0110 with data1=0x3C, data2=0xC3 → requester 1 is sent first (0,0,0,1,1,1,1,0,0,1), then requester 2. The second start bit comes exactly 12 cycles after the first (GAP_BITS=1).
- Round-robin fairness: req=4'b1111 held, each requester re-asserting after gnt, 8 frames → gnt order 0,1,2,3,0,1,2,3. No gnt while busy=1.
- GAP_BITS=0 build, back-to-back requests → exactly 1 idle-1 cycle between the stop bit and the next start bit.
- Reset at the 4th data bit of a frame → tx=1, busy=0, no frame_done the next cycle. A subsequent req=4'b1000 is granted to requester 3 and the full frame is sent.
- en=0 with req=4'b0001 for 20 cycles → no gnt, tx=1 throughout. Raise en → gnt[0] in that same cycle. Dropping en mid-frame still completes the frame with frame_done.
